alu: RTL and testbench

Single-cycle RV32IM execute-stage ALU. Takes decoded one-hot operation enables, register operands, pre-extended immediates, shift amount and PC. Computes the integer, M-extension, store-address, LUI and AUIPC result and registers it. The registered result and its sign flag feed writeback and the load/store unit.

---
 rtl/alu.sv | 130 +++++++++++++
 tb/tb_alu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle RV32IM execute ALU with a registered result and sign flag.
// Define ALU_M_EXT_EN to build the multiply/divide/remainder datapath.
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] RS1,
   input  logic [31:0] RS2,
   input  logic [31:0] IM_32_I,
   input  logic [31:0] IM_32_S,
   input  logic [31:0] IM_32_U,
   input  logic [31:0] PC,
   input  logic [4:0]  shift_amount,
   input  logic        add_en,
   input  logic        sub_en,
   input  logic        and_en,
   input  logic        or_en,
   input  logic        xor_en,
   input  logic        sll_en,
   input  logic        srl_en,
   input  logic        sra_en,
   input  logic        slt_en,
   input  logic        addi_en,
   input  logic        andi_en,
   input  logic        ori_en,
   input  logic        xori_en,
   input  logic        slti_en,
   input  logic        sltiu_en,
   input  logic        slli_en,
   input  logic        srli_en,
   input  logic        srai_en,
   input  logic        mul_en,
   input  logic        mulh_en,
   input  logic        mulhsu_en,
   input  logic        mulhu_en,
   input  logic        div_en,
   input  logic        divu_en,
   input  logic        rem_en,
   input  logic        remu_en,
   input  logic        sw_en,
   input  logic        sh_en,
   input  logic        sb_en,
   input  logic        lui_en,
   input  logic        auipc_en,
   output logic [31:0] alu_out,
   output logic        neg_flag
);

   logic [31:0] result;
   logic [31:0] imm_u;

   assign imm_u = {IM_32_U[19:0], 12'b0};

`ifdef ALU_M_EXT_EN
   logic [63:0] prod_ss, prod_su, prod_uu;
   logic [31:0] div_b, abs_a, abs_b, quo_u, rem_u, quo_mag, rem_mag, quo_s, rem_s;
   logic        b_zero;

   // All three products are taken modulo 2^64 on extended operands, so the
   // high word comes out right for every signedness combination.
   assign prod_ss = {{32{RS1[31]}}, RS1} * {{32{RS2[31]}}, RS2};
   assign prod_su = {{32{RS1[31]}}, RS1} * {32'b0, RS2};
   assign prod_uu = {32'b0, RS1} * {32'b0, RS2};

   // Signed divide goes through magnitudes; 0x80000000 / -1 then falls out
   // as 0x80000000 with remainder 0 without a special case.
   assign b_zero  = (RS2 == 32'b0);
   assign div_b   = b_zero ? 32'd1 : RS2;
   assign quo_u   = RS1 / div_b;
   assign rem_u   = RS1 % div_b;
   assign abs_a   = RS1[31] ? -RS1 : RS1;
   assign abs_b   = div_b[31] ? -div_b : div_b;
   assign quo_mag = abs_a / abs_b;
   assign rem_mag = abs_a % abs_b;
   assign quo_s   = (RS1[31] ^ RS2[31]) ? -quo_mag : quo_mag;
   assign rem_s   = RS1[31] ? -rem_mag : rem_mag;

   logic unused_bits;
   assign unused_bits = ^{IM_32_U[31:20], prod_su[31:0], prod_uu[31:0], prod_ss[63:32]};
`else
   logic unused_bits;
   assign unused_bits = ^{IM_32_U[31:20], mul_en, mulh_en, mulhsu_en, mulhu_en,
                          div_en, divu_en, rem_en, remu_en};
`endif

   always_comb begin
      result = 32'b0;
      if      (add_en)   result = RS1 + RS2;
      else if (sub_en)   result = RS1 - RS2;
      else if (and_en)   result = RS1 & RS2;
      else if (or_en)    result = RS1 | RS2;
      else if (xor_en)   result = RS1 ^ RS2;
      else if (sll_en)   result = RS1 << shift_amount;
      else if (srl_en)   result = RS1 >> shift_amount;
      else if (sra_en)   result = 32'($signed(RS1) >>> shift_amount);
      else if (slt_en)   result = {31'b0, $signed(RS1) < $signed(RS2)};
      else if (addi_en)  result = RS1 + IM_32_I;
      else if (andi_en)  result = RS1 & IM_32_I;
      else if (ori_en)   result = RS1 | IM_32_I;
      else if (xori_en)  result = RS1 ^ IM_32_I;
      else if (slti_en)  result = {31'b0, $signed(RS1) < $signed(IM_32_I)};
      else if (sltiu_en) result = {31'b0, RS1 < IM_32_I};
      else if (slli_en)  result = RS1 << shift_amount;
      else if (srli_en)  result = RS1 >> shift_amount;
      else if (srai_en)  result = 32'($signed(RS1) >>> shift_amount);
`ifdef ALU_M_EXT_EN
      else if (mul_en)    result = prod_ss[31:0];
      else if (mulh_en)   result = prod_ss[63:32];
      else if (mulhsu_en) result = prod_su[63:32];
      else if (mulhu_en)  result = prod_uu[63:32];
      else if (div_en)    result = b_zero ? 32'hFFFF_FFFF : quo_s;
      else if (divu_en)   result = b_zero ? 32'hFFFF_FFFF : quo_u;
      else if (rem_en)    result = b_zero ? RS1 : rem_s;
      else if (remu_en)   result = b_zero ? RS1 : rem_u;
`endif
      else if (sw_en || sh_en || sb_en) result = RS1 + IM_32_S;
      else if (lui_en)   result = imm_u;
      else if (auipc_en) result = PC + imm_u;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out  <= 32'b0;
         neg_flag <= 1'b0;
      end else begin
         alu_out  <= result;
         neg_flag <= result[31];
      end
   end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed checks of alu against a priority-list reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rs1, rs2, imi, ims, imu, pc;
   logic [4:0]  sh;
   logic [30:0] en;
   logic [31:0] alu_out;
   logic        neg_flag;

   int checks   = 0;
   int failures = 0;

`ifdef ALU_M_EXT_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   // Enable bit index == priority rank (0 is highest).
   localparam int ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8;
   localparam int ADDI=9, ANDI=10, ORI=11, XORI=12, SLTI=13, SLTIU=14, SLLI=15, SRLI=16, SRAI=17;
   localparam int MUL=18, MULH=19, MULHSU=20, MULHU=21, DIV=22, DIVU=23, REM=24, REMU=25;
   localparam int SW=26, SH=27, SB=28, LUI=29, AUIPC=30;

   always #5 clk = ~clk;

   alu dut (
      .clk(clk), .rst(rst), .RS1(rs1), .RS2(rs2), .IM_32_I(imi), .IM_32_S(ims),
      .IM_32_U(imu), .PC(pc), .shift_amount(sh),
      .add_en(en[ADD]), .sub_en(en[SUB]), .and_en(en[AND]), .or_en(en[OR]),
      .xor_en(en[XOR]), .sll_en(en[SLL]), .srl_en(en[SRL]), .sra_en(en[SRA]),
      .slt_en(en[SLT]), .addi_en(en[ADDI]), .andi_en(en[ANDI]), .ori_en(en[ORI]),
      .xori_en(en[XORI]), .slti_en(en[SLTI]), .sltiu_en(en[SLTIU]), .slli_en(en[SLLI]),
      .srli_en(en[SRLI]), .srai_en(en[SRAI]), .mul_en(en[MUL]), .mulh_en(en[MULH]),
      .mulhsu_en(en[MULHSU]), .mulhu_en(en[MULHU]), .div_en(en[DIV]), .divu_en(en[DIVU]),
      .rem_en(en[REM]), .remu_en(en[REMU]), .sw_en(en[SW]), .sh_en(en[SH]),
      .sb_en(en[SB]), .lui_en(en[LUI]), .auipc_en(en[AUIPC]),
      .alu_out(alu_out), .neg_flag(neg_flag)
   );

   function automatic logic [31:0] op_value(input int op, input logic [31:0] a, b, ii, is, iu, p,
                                            input logic [4:0] s);
      longint sa, sb, r;
      logic [63:0] u;
      logic [31:0] up;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      up = iu << 12;
      case (op)
         ADD:   return a + b;
         SUB:   return a - b;
         AND:   return a & b;
         OR:    return a | b;
         XOR:   return a ^ b;
         SLL, SLLI: return a << s;
         SRL, SRLI: return a >> s;
         SRA, SRAI: begin r = sa >>> s; return 32'(r); end
         SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         ADDI:  return a + ii;
         ANDI:  return a & ii;
         ORI:   return a | ii;
         XORI:  return a ^ ii;
         SLTI:  return (int'(a) < int'(ii)) ? 32'd1 : 32'd0;
         SLTIU: return (a < ii) ? 32'd1 : 32'd0;
         MUL:   begin r = sa * sb; return 32'(r); end
         MULH:  begin r = sa * sb; r = r >>> 32; return 32'(r); end
         MULHSU: begin r = sa * longint'({32'b0, b}); r = r >>> 32; return 32'(r); end
         MULHU: begin u = {32'b0, a} * {32'b0, b}; u = u >> 32; return 32'(u); end
         DIV:   begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; return 32'(r); end
         DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:   begin if (b == 0) return a; r = sa % sb; return 32'(r); end
         REMU:  return (b == 0) ? a : a % b;
         SW, SH, SB: return a + is;
         LUI:   return up;
         AUIPC: return p + up;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model(input logic [30:0] e, input logic [31:0] a, b, ii, is, iu, p,
                                         input logic [4:0] s);
      for (int i = 0; i < 31; i++) begin
         if (e[i] && (M_EXT || i < MUL || i > REMU))
            return op_value(i, a, b, ii, is, iu, p, s);
      end
      return 32'd0;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '0; en[ADD] = 1'b1;
      rs1 = 32'h10; rs2 = 32'h4; imi = '0; ims = '0; imu = '0; pc = '0; sh = '0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (alu_out !== 32'd0 || neg_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset cycle%0d got out=%h neg=%b exp out=0 neg=0", k, alu_out, neg_flag);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (alu_out !== 32'h14) begin
         failures++;
         $display("FAIL reset_release got=%h exp=00000014", alu_out);
      end
   endtask

   task automatic test_basic();
      int          ops[8] = '{SUB, XOR, SLL, SRA, ADDI, ANDI, SLTI, SLTIU};
      logic [31:0] exp[8] = '{32'hC, 32'h14, 32'h40, 32'h4, 32'h0, 32'h10, 32'h0, 32'h1};
      rs1 = 32'h10; rs2 = 32'h4; imi = 32'hFFFF_FFF0; sh = 5'd2;
      for (int k = 0; k < 8; k++) begin
         en = 31'd1 << ops[k];
         tick();
         checks++;
         if (alu_out !== exp[k]) begin
            failures++;
            $display("FAIL basic op%0d got=%h exp=%h", ops[k], alu_out, exp[k]);
         end
      end
   endtask

   task automatic test_upper_store();
      int          ops[5] = '{LUI, AUIPC, SW, SH, SB};
      logic [31:0] exp[5] = '{32'h12000, 32'h12080, 32'h18, 32'h18, 32'h18};
      rs1 = 32'h10; imu = 32'h12; pc = 32'h80; ims = 32'h8;
      for (int k = 0; k < 5; k++) begin
         en = 31'd1 << ops[k];
         tick();
         checks++;
         if (alu_out !== exp[k]) begin
            failures++;
            $display("FAIL upper_store op%0d got=%h exp=%h", ops[k], alu_out, exp[k]);
         end
      end
   endtask

   task automatic test_mul();
      int          ops[4] = '{MUL, MULH, MULHSU, MULHU};
      logic [31:0] exp[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
      logic [31:0] e;
      rs1 = 32'hFFFF_FFFF; rs2 = 32'h2;
      for (int k = 0; k < 4; k++) begin
         en = 31'd1 << ops[k];
         e = M_EXT ? exp[k] : 32'd0;
         tick();
         checks++;
         if (alu_out !== e || neg_flag !== e[31]) begin
            failures++;
            $display("FAIL mul op%0d got=%h neg=%b exp=%h neg=%b", ops[k], alu_out, neg_flag, e, e[31]);
         end
      end
   endtask

   task automatic test_div();
      int          ops[6] = '{DIV, DIVU, REMU, DIV, REM, REM};
      logic [31:0] a[6]   = '{32'h10, 32'h10, 32'h10, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
      logic [31:0] b[6]   = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2};
      logic [31:0] exp[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
      logic [31:0] e;
      for (int k = 0; k < 6; k++) begin
         en = 31'd1 << ops[k]; rs1 = a[k]; rs2 = b[k];
         e = M_EXT ? exp[k] : 32'd0;
         tick();
         checks++;
         if (alu_out !== e) begin
            failures++;
            $display("FAIL div_corner%0d op%0d got=%h exp=%h", k, ops[k], alu_out, e);
         end
      end
   endtask

   task automatic test_priority();
      rs1 = 32'h10; rs2 = 32'h4; ims = 32'h8;
      en = '0; en[ADD] = 1'b1; en[SUB] = 1'b1;
      tick(); checks++;
      if (alu_out !== 32'h14) begin
         failures++; $display("FAIL prio_add_sub got=%h exp=00000014", alu_out);
      end
      en = '0;
      tick(); checks++;
      if (alu_out !== 32'h0 || neg_flag !== 1'b0) begin
         failures++; $display("FAIL idle got=%h neg=%b exp=0", alu_out, neg_flag);
      end
      en[MUL] = 1'b1;
      tick(); checks++;
      if (alu_out !== (M_EXT ? 32'h40 : 32'h0)) begin
         failures++; $display("FAIL mul_alone got=%h exp=%h", alu_out, M_EXT ? 32'h40 : 32'h0);
      end
      en[SW] = 1'b1;
      tick(); checks++;
      if (alu_out !== (M_EXT ? 32'h40 : 32'h18)) begin
         failures++; $display("FAIL mul_sw got=%h exp=%h", alu_out, M_EXT ? 32'h40 : 32'h18);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 15) == 0);
         rs1 = rnd_val(); rs2 = rnd_val(); imi = rnd_val(); ims = rnd_val();
         imu = $urandom; pc = $urandom; sh = 5'($urandom);
         case ($urandom_range(0, 9))
            0: en = '0;
            1: en = 31'($urandom);
            2: begin en = '0; en[$urandom_range(0, 30)] = 1'b1; en[$urandom_range(0, 30)] = 1'b1; end
            default: begin en = '0; en[$urandom_range(0, 30)] = 1'b1; end
         endcase
         e = rst ? 32'd0 : model(en, rs1, rs2, imi, ims, imu, pc, sh);
         tick();
         checks++;
         if (alu_out !== e || neg_flag !== e[31]) begin
            failures++;
            $display("FAIL random%0d en=%h rs1=%h rs2=%h rst=%b got=%h neg=%b exp=%h",
                     n, en, rs1, rs2, rst, alu_out, neg_flag, e);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_upper_store();
      test_mul();
      test_div();
      test_priority();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
